// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scroll sequencer.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 6;

  // Segment mask seen by the decoder: it ANDs with active-low segments,
  // so all-ones passes the decoded pattern and all-zeros lights every segment.
  localparam logic [6:0] SEG_PASS   = 7'h7F;
  localparam logic [6:0] SEG_ALL_ON = 7'h00;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHOW   = 2'd2,
    SCROLL = 2'd3
  } state_t;

  function automatic logic [6:0] seg_mask(input logic lamp_test);
    return lamp_test ? SEG_ALL_ON : SEG_PASS;
  endfunction

endpackage

// File: rtl/seven_seg_tick_gen.sv
// Scroll-rate prescaler: counts 0..TICK_DIV-1 while enabled, tick on the last count.
module seven_seg_tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: synchronous clear wins, then wrap at the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/seven_seg_scroll_ctrl.sv
// Message buffer and display sequencer feeding the six-digit segment decoder.
//
//   state  | meaning
//   IDLE   | accepting nibbles into the buffer
//   LOADED | message complete, first six nibbles shown
//   SHOW   | static window at the held offset
//   SCROLL | window advances one nibble per prescaler tick
module seven_seg_scroll_ctrl
  import seven_seg_pkg::*;
#(
  parameter int BUF_DEPTH = 16,
  parameter int TICK_DIV  = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  input  logic [3:0] wr_nibble_i,
  input  logic       wr_last_i,
  input  logic       scroll_en_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       clear_i,
  input  logic       lamp_test_i,
  output logic       busy_o,
  output logic       wrap_o,
  output logic [3:0] bcd0_o,
  output logic [3:0] bcd1_o,
  output logic [3:0] bcd2_o,
  output logic [3:0] bcd3_o,
  output logic [3:0] bcd4_o,
  output logic [3:0] bcd5_o,
  output logic [6:0] turn_on_o
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int LW = AW + 1;
  // Window index reaches offset+5 < len+6, so three spare bits cover it.
  localparam int IW = LW + 3;
  localparam logic [LW-1:0] DEPTH_L = LW'(BUF_DEPTH);

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] offset_q, offset_d;
  nibble_t       buf_q [BUF_DEPTH];

  nibble_t       bcd_q [NUM_DIGITS];
  nibble_t       bcd_d [NUM_DIGITS];
  logic [IW-1:0] win_idx [NUM_DIGITS];
  logic [6:0]    turn_on_q;
  logic          busy_q;
  logic          wrap_q, wrap_d;

  logic          wr_ready;
  logic          wr_acc;
  logic          start_eff;
  logic          tick;
  logic          in_scroll;
  logic [LW-1:0] len_m1;
  logic          at_end;

  assign wr_ready  = (state_q == IDLE) && (len_q < DEPTH_L) && !clear_i;
  assign wr_acc    = wr_valid_i && wr_ready;
  assign start_eff = start_i && !stop_i;
  assign in_scroll = (state_q == SCROLL);
  assign len_m1    = len_q - 1'b1;
  assign at_end    = ({1'b0, offset_q} == len_m1);

  // Prescaler only runs in SCROLL and sits at zero everywhere else,
  // so every entry into SCROLL starts a full TICK_DIV period.
  seven_seg_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (in_scroll),
    .clr_i (!in_scroll),
    .tick_o(tick)
  );

  // Next state and message length; clear beats stop beats start.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (clear_i) begin
      state_d = IDLE;
      len_d   = '0;
    end else begin
      if (wr_acc) begin
        len_d = len_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (wr_acc && (wr_last_i || (len_q == DEPTH_L - 1'b1))) begin
            state_d = LOADED;
          end else if (start_eff && (len_q != '0)) begin
            state_d = LOADED;
          end
        end
        LOADED, SHOW: begin
          if (start_eff) begin
            state_d = scroll_en_i ? SCROLL : SHOW;
          end
        end
        SCROLL: begin
          if (stop_i) begin
            state_d = SHOW;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Scroll offset; a stop in the same cycle as a tick freezes the offset.
  always_comb begin
    offset_d = offset_q;
    wrap_d   = 1'b0;
    if (clear_i) begin
      offset_d = '0;
    end else if (in_scroll && !stop_i && tick) begin
      if (at_end) begin
        offset_d = '0;
        wrap_d   = 1'b1;
      end else begin
        offset_d = offset_q + 1'b1;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      offset_q <= offset_d;
    end
  end

  // Message storage; contents are only meaningful below len, so no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      buf_q[len_q[AW-1:0]] <= wr_nibble_i;
    end
  end

  // Window index per digit: (offset+i) mod len by repeated conditional
  // subtraction; six passes cover the worst case of a one-nibble message.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      win_idx[i] = IW'(offset_q) + IW'(i);
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if ((len_q != '0) && (win_idx[i] >= IW'(len_q))) begin
          win_idx[i] = win_idx[i] - IW'(len_q);
        end
      end
    end
  end

  // Digit selection; leftmost digit (bcd5) shows window position 0.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_d[NUM_DIGITS-1-i] = '0;
      if ((state_q == SHOW) || (state_q == SCROLL)) begin
        if (len_q != '0) begin
          bcd_d[NUM_DIGITS-1-i] = buf_q[win_idx[i][AW-1:0]];
        end
      end else if (LW'(i) < len_q) begin
        bcd_d[NUM_DIGITS-1-i] = buf_q[AW'(i)];
      end
    end
  end

  // Registered decoder-facing outputs, one cycle behind the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        bcd_q[k] <= '0;
      end
      turn_on_q <= SEG_PASS;
      busy_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        bcd_q[k] <= bcd_d[k];
      end
      turn_on_q <= seg_mask(lamp_test_i);
      busy_q    <= in_scroll;
      wrap_q    <= wrap_d;
    end
  end

  assign wr_ready_o = wr_ready;
  assign busy_o     = busy_q;
  assign wrap_o     = wrap_q;
  assign turn_on_o  = turn_on_q;
  assign bcd0_o     = bcd_q[0];
  assign bcd1_o     = bcd_q[1];
  assign bcd2_o     = bcd_q[2];
  assign bcd3_o     = bcd_q[3];
  assign bcd4_o     = bcd_q[4];
  assign bcd5_o     = bcd_q[5];

endmodule
